// File: rtl/cla_acc_controller.sv
// Operand controller: register A, button-driven ADD/SUB/ACC/PASS with registered result and flags.
// Optional per-button debounce enabled by defining CLA_ACC_DEBOUNCE_EN.

module cla_btn_cond #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic live,
    input  logic raw,
    output logic pulse
);
    logic sync1_q, sync2_q, prev_q, arm_q;
    logic arm_d;
    logic lvl;

`ifdef CLA_ACC_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic          lvl_q, lvl_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        lvl_d = lvl_q;
        cnt_d = '0;
        if (sync2_q != lvl_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                lvl_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            lvl_q <= lvl_d;
            cnt_q <= cnt_d;
        end
    end

    assign lvl = lvl_q;
`else
    assign lvl = sync2_q;
`endif

    // Arm only once real samples have reached the synchroniser, so a button
    // held through reset cannot masquerade as a fresh rising edge.
    assign arm_d = arm_q | (live & ~sync1_q & ~lvl);
    assign pulse = lvl & ~prev_q & arm_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            arm_q   <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            prev_q  <= lvl;
            arm_q   <= arm_d;
        end
    end
endmodule

module cla_acc_controller #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             store_A,
    input  logic             exec,
    input  logic [1:0]       op,
    input  logic             cin,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             valid,
    output logic [WIDTH-1:0] numA
);
    typedef enum logic { EMPTY, READY } state_t;
    localparam logic [1:0] OP_SUB = 2'b01, OP_ACC = 2'b10, OP_PASS = 2'b11;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] numa_q, numa_d, out_q, out_d;
    logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d, valid_q, valid_d;
    logic             live_q;
    logic             store_p, exec_p;

    logic [WIDTH-1:0] b_eff, res;
    logic [WIDTH:0]   sum;
    logic             c_eff, res_cout, res_ovf;

    cla_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_store (
        .clk(clk), .rst(rst), .live(live_q), .raw(store_A), .pulse(store_p)
    );
    cla_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exec (
        .clk(clk), .rst(rst), .live(live_q), .raw(exec), .pulse(exec_p)
    );

    always_comb begin
        b_eff    = (op == OP_SUB) ? ~in : in;
        c_eff    = (op == OP_SUB) ? 1'b1 : cin;
        sum      = {1'b0, numa_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, c_eff};
        res      = sum[WIDTH-1:0];
        res_cout = sum[WIDTH];
        res_ovf  = (numa_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != numa_q[WIDTH-1]);
        if (op == OP_PASS) begin
            res      = in;
            res_cout = 1'b0;
            res_ovf  = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        numa_d  = numa_q;
        out_d   = out_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        valid_d = 1'b0;
        case (state_q)
            EMPTY: begin
                if (store_p) begin
                    numa_d  = in;
                    state_d = READY;
                end
            end
            READY: begin
                // A simultaneous exec is dropped: the load takes priority.
                if (store_p) begin
                    numa_d = in;
                end else if (exec_p) begin
                    out_d   = res;
                    cout_d  = res_cout;
                    ovf_d   = res_ovf;
                    zero_d  = (res == '0);
                    valid_d = 1'b1;
                    if (op == OP_ACC) numa_d = res;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            numa_q  <= '0;
            out_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b1;
            valid_q <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            numa_q  <= numa_d;
            out_q   <= out_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            valid_q <= valid_d;
            live_q  <= 1'b1;
        end
    end

    assign out   = out_q;
    assign cout  = cout_q;
    assign ovf   = ovf_q;
    assign zero  = zero_q;
    assign valid = valid_q;
    assign numA  = numa_q;
endmodule
